// File: rtl/serial_pattern_ctrl.sv
// serial_pattern_ctrl: configurable serial bit-pattern detector with match counting and auto-stop
module serial_pattern_ctrl #(
  parameter int PW = 8,
  parameter int LW = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_pattern,
  input  logic [LW-1:0] cfg_len,
  input  logic          cfg_overlap,
  input  logic [CW-1:0] cfg_target,
  input  logic          start,
  input  logic          abort,
  input  logic          in,
  input  logic          in_valid,
  output logic          out,
  output logic [CW-1:0] match_count,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pat_q, pat_d, hist_q, hist_d, hist_n;
  logic [LW-1:0] len_q, len_d, fill_q, fill_d, fill_n;
  logic [CW-1:0] tgt_q, tgt_d, cnt_q, cnt_d;
  logic ovl_q, ovl_d, out_q, out_d, match;
  always_comb begin
    hist_n = (hist_q << 1) | PW'(in);
    fill_n = fill_q == len_q ? len_q : fill_q + LW'(1);
    match = fill_n == len_q && ((hist_n ^ pat_q) & ~({PW{1'b1}} << len_q)) == '0;
    state_d = state_q;
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    tgt_d = tgt_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d = cnt_q;
    out_d = 1'b0;
    if (cfg_we && state_q != ARMED) begin
      pat_d = cfg_pattern;
      len_d = cfg_len == '0 ? LW'(1) : cfg_len > LW'(PW) ? LW'(PW) : cfg_len;
      ovl_d = cfg_overlap;
      tgt_d = cfg_target;
    end
    if (abort) begin
      state_d = IDLE;
    end else if (start && state_q != ARMED) begin
      state_d = ARMED;
      hist_d = '0;
      fill_d = '0;
      cnt_d = '0;
    end else if (state_q == ARMED && in_valid) begin
      hist_d = hist_n;
      fill_d = match && !ovl_q ? '0 : fill_n;
      out_d = match;
      cnt_d = match && !(tgt_q == '0 && cnt_q == '1) ? cnt_q + CW'(1) : cnt_q;
      state_d = match && tgt_q != '0 && cnt_q + CW'(1) == tgt_q ? DONE : ARMED;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q <= PW'(1);
      len_q <= LW'(1);
      ovl_q <= 1'b0;
      tgt_q <= '0;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      tgt_q <= tgt_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end
  assign out = out_q;
  assign match_count = cnt_q;
  assign busy = state_q == ARMED;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_serial_pattern_ctrl.sv
// tb_serial_pattern_ctrl: directed and randomized checks of serial_pattern_ctrl against a bit-queue model
module tb_serial_pattern_ctrl;
  localparam int PW = 8;
  localparam int LW = 4;
  localparam int CW = 8;
  logic clk = 1'b0;
  logic rst, cfg_we, cfg_overlap, start, abort, in, in_valid;
  logic [PW-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_target;
  logic out, busy, done;
  logic [CW-1:0] match_count;
  int n_cmp = 0;
  int n_bad = 0;
  int m_st, m_cnt, m_pat, m_len, m_tgt;
  bit m_out, m_ovl;
  bit m_bits[$];
  always #5 clk = ~clk;
  serial_pattern_ctrl #(.PW(PW), .LW(LW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_target(cfg_target), .start(start), .abort(abort),
    .in(in), .in_valid(in_valid), .out(out), .match_count(match_count), .busy(busy), .done(done)
  );
  task automatic m_reset();
    m_st = 0;
    m_cnt = 0;
    m_out = 0;
    m_pat = 1;
    m_len = 1;
    m_ovl = 0;
    m_tgt = 0;
    m_bits.delete();
  endtask
  task automatic m_edge();
    int v;
    m_out = 0;
    if (cfg_we && m_st != 1) begin
      m_pat = int'(cfg_pattern);
      m_len = cfg_len == 0 ? 1 : int'(cfg_len) > PW ? PW : int'(cfg_len);
      m_ovl = cfg_overlap;
      m_tgt = int'(cfg_target);
    end
    if (abort) m_st = 0;
    else if (start && m_st != 1) begin
      m_st = 1;
      m_cnt = 0;
      m_bits.delete();
    end else if (m_st == 1 && in_valid) begin
      m_bits.push_back(in);
      if (m_bits.size() > PW) void'(m_bits.pop_front());
      if (m_bits.size() >= m_len) begin
        v = 0;
        for (int i = 0; i < m_len; i++) v |= int'(m_bits[m_bits.size() - 1 - i]) << i;
        if (v == (m_pat & ((1 << m_len) - 1))) begin
          m_out = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
          if (!m_ovl) m_bits.delete();
          if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
        end
      end
    end
  endtask
  task automatic cyc(bit v, bit b, bit s = 0, bit a = 0);
    in_valid = v;
    in = b;
    start = s;
    abort = a;
    @(posedge clk);
    m_edge();
    #1;
    in_valid = 0;
    start = 0;
    abort = 0;
    cfg_we = 0;
  endtask
  task automatic cfg(int pat, int len, bit ovl, int tgt, bit s);
    cfg_pattern = PW'(pat);
    cfg_len = LW'(len);
    cfg_overlap = ovl;
    cfg_target = CW'(tgt);
    cfg_we = 1;
    cyc(0, 0, s);
  endtask
  task automatic test_reset();
    n_cmp++;
    if ({out, busy, done, match_count} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL reset: got out=%b busy=%b done=%b cnt=%0d want 0/0/0/0", out, busy, done, match_count);
    end
  endtask
  task automatic test_default();
    bit s[10] = '{0, 1, 1, 1, 0, 1, 0, 1, 1, 1};
    cyc(0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      cyc(1, s[i]);
      n_cmp++;
      if ({out, busy, done} !== {s[i], 1'b1, 1'b0}) begin
        n_bad++;
        $display("FAIL default bit%0d: got out=%b busy=%b done=%b want %b/1/0", i, out, busy, done, s[i]);
      end
    end
    n_cmp++;
    if (match_count !== CW'(7)) begin
      n_bad++;
      $display("FAIL default_count: got %0d want 7", match_count);
    end
  endtask
  task automatic test_overlap();
    bit s[7] = '{1, 0, 1, 1, 0, 1, 1};
    bit e1[7] = '{0, 0, 0, 1, 0, 0, 1};
    bit e0[7] = '{0, 0, 0, 1, 0, 0, 0};
    for (int o = 1; o >= 0; o--) begin
      cyc(0, 0, 0, 1);
      cfg(4'b1011, 4, o[0], 0, 1);
      for (int i = 0; i < 7; i++) begin
        cyc(1, s[i]);
        n_cmp++;
        if (out !== (o == 1 ? e1[i] : e0[i])) begin
          n_bad++;
          $display("FAIL overlap%0d bit%0d: got out=%b want %b", o, i, out, o == 1 ? e1[i] : e0[i]);
        end
      end
      n_cmp++;
      if (match_count !== CW'(o == 1 ? 2 : 1)) begin
        n_bad++;
        $display("FAIL overlap%0d_count: got %0d want %0d", o, match_count, o == 1 ? 2 : 1);
      end
    end
  endtask
  task automatic test_target();
    cyc(0, 0, 0, 1);
    cfg(1, 1, 0, 3, 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1);
      n_cmp++;
      if ({out, busy, done, match_count} !== {k < 3, k < 2, k >= 2, CW'(k < 3 ? k + 1 : 3)}) begin
        n_bad++;
        $display("FAIL target bit%0d: got out=%b busy=%b done=%b cnt=%0d want %b/%b/%b/%0d",
                 k, out, busy, done, match_count, k < 3, k < 2, k >= 2, k < 3 ? k + 1 : 3);
      end
    end
    cyc(0, 0, 1);
    n_cmp++;
    if ({busy, done, match_count} !== {1'b1, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL target_rearm: got busy=%b done=%b cnt=%0d want 1/0/0", busy, done, match_count);
    end
  endtask
  task automatic test_gaps();
    cyc(0, 0, 0, 1);
    cfg(2'b11, 2, 0, 0, 1);
    cyc(1, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      n_cmp++;
      if (out !== 1'b0) begin
        n_bad++;
        $display("FAIL gap%0d: got out=%b want 0", i, out);
      end
    end
    cyc(1, 1);
    n_cmp++;
    if ({out, match_count} !== {1'b1, CW'(1)}) begin
      n_bad++;
      $display("FAIL gap_match: got out=%b cnt=%0d want 1/1", out, match_count);
    end
    cyc(0, 0, 0, 1);
    cfg(1, 0, 0, 0, 1);
    cyc(1, 1);
    n_cmp++;
    if (out !== 1'b1) begin
      n_bad++;
      $display("FAIL len0_clamp: got out=%b want 1", out);
    end
    cfg_pattern = '0;
    cfg_we = 1;
    cyc(1, 1);
    n_cmp++;
    if ({out, match_count} !== {1'b1, CW'(2)}) begin
      n_bad++;
      $display("FAIL locked_cfg: got out=%b cnt=%0d want 1/2", out, match_count);
    end
    cyc(1, 0);
    n_cmp++;
    if (out !== 1'b0) begin
      n_bad++;
      $display("FAIL locked_cfg_zero: got out=%b want 0", out);
    end
  endtask
  task automatic test_abort();
    cyc(0, 0, 0, 1);
    cfg(1, 1, 0, 0, 1);
    cyc(1, 1);
    cyc(1, 1);
    cyc(1, 1, 1, 1);
    n_cmp++;
    if ({out, busy, done, match_count} !== {1'b0, 1'b0, 1'b0, CW'(2)}) begin
      n_bad++;
      $display("FAIL abort: got out=%b busy=%b done=%b cnt=%0d want 0/0/0/2", out, busy, done, match_count);
    end
    cyc(1, 1);
    n_cmp++;
    if ({out, busy, match_count} !== {1'b0, 1'b0, CW'(2)}) begin
      n_bad++;
      $display("FAIL abort_idle: got out=%b busy=%b cnt=%0d want 0/0/2", out, busy, match_count);
    end
  endtask
  task automatic test_saturate();
    cyc(0, 0, 0, 1);
    cfg(1, 1, 1, 0, 1);
    for (int i = 0; i < 258; i++) cyc(1, 1);
    n_cmp++;
    if ({out, busy, match_count} !== {1'b1, 1'b1, CW'(255)}) begin
      n_bad++;
      $display("FAIL saturate: got out=%b busy=%b cnt=%0d want 1/1/255", out, busy, match_count);
    end
  endtask
  task automatic test_async_reset();
    cyc(0, 0, 0, 1);
    cfg(0, 1, 0, 0, 1);
    cyc(1, 0);
    n_cmp++;
    if (out !== 1'b1) begin
      n_bad++;
      $display("FAIL async_pre: got out=%b want 1", out);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({out, busy, done, match_count} !== {1'b0, 1'b0, 1'b0, CW'(0)}) begin
      n_bad++;
      $display("FAIL async_reset: got out=%b busy=%b done=%b cnt=%0d want 0/0/0/0", out, busy, done, match_count);
    end
    #1 rst = 0;
    m_reset();
    cyc(0, 0, 1);
    cyc(1, 1);
    n_cmp++;
    if (out !== 1'b1) begin
      n_bad++;
      $display("FAIL async_cfg_one: got out=%b want 1", out);
    end
    cyc(1, 0);
    n_cmp++;
    if (out !== 1'b0) begin
      n_bad++;
      $display("FAIL async_cfg_zero: got out=%b want 0", out);
    end
  endtask
  task automatic test_random();
    int len;
    for (int r = 0; r < 20; r++) begin
      cyc(0, 0, 0, 1);
      len = ($urandom % 4 == 0) ? $urandom_range(5, 15) : $urandom_range(0, 3);
      cfg($urandom, len, $urandom_range(0, 1), $urandom_range(0, 4), 1);
      for (int c = 0; c < 80; c++) begin
        if ($urandom % 15 == 0) begin
          cfg_pattern = PW'($urandom);
          cfg_len = LW'($urandom_range(0, 15));
          cfg_overlap = 1'($urandom);
          cfg_target = CW'($urandom_range(0, 4));
          cfg_we = 1;
        end
        cyc(1'($urandom), 1'($urandom), $urandom % 20 == 0, $urandom % 40 == 0);
        n_cmp++;
        if ({out, busy, done, match_count} !== {m_out, m_st == 1, m_st == 2, CW'(m_cnt)}) begin
          n_bad++;
          $display("FAIL random r%0d c%0d: got out=%b busy=%b done=%b cnt=%0d want %b/%b/%b/%0d",
                   r, c, out, busy, done, match_count, m_out, m_st == 1, m_st == 2, m_cnt);
        end
      end
    end
  endtask
  initial begin
    rst = 1;
    cfg_we = 0;
    cfg_pattern = '0;
    cfg_len = '0;
    cfg_overlap = 0;
    cfg_target = '0;
    start = 0;
    abort = 0;
    in = 0;
    in_valid = 0;
    m_reset();
    #12;
    test_reset();
    rst = 0;
    test_default();
    test_overlap();
    test_target();
    test_gaps();
    test_abort();
    test_saturate();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
